// File: rtl/count_stream_checker_pkg.sv
// Shared types and constants for the counter stream checker.
// Default bus geometry matches the up/down counter it monitors.
package count_stream_checker_pkg;

  localparam int DEF_WIDTH   = 5;
  localparam int DEF_MAX_VAL = 30;

  typedef logic [1:0] state_t;

  localparam state_t ST_UNLOCKED = 2'd0;
  localparam state_t ST_ACQUIRE  = 2'd1;
  localparam state_t ST_LOCKED   = 2'd2;

  function automatic int unsigned cnt_succ(
    input int unsigned x,
    input int unsigned mx
  );
    return (x == mx) ? 0 : x + 1;
  endfunction

  function automatic int unsigned cnt_pred(
    input int unsigned x,
    input int unsigned mx
  );
    return (x == 0) ? mx : x - 1;
  endfunction

endpackage

// File: rtl/count_step.sv
// One step of the 0..MAX_VAL counter ring in either direction.
// wrap is set when the step crosses the MAX_VAL/0 seam.
module count_step
  import count_stream_checker_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic [WIDTH-1:0] x,
  input  logic             up,
  output logic [WIDTH-1:0] y,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);

  // Successor or predecessor with wrap detection
  always_comb begin
    if (up) begin
      wrap = (x == TOP);
      y    = wrap ? '0 : x + WIDTH'(1);
    end else begin
      wrap = (x == '0);
      y    = wrap ? TOP : x - WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_stream_checker.sv
// Consumer-side monitor for the up/down counter stream.
// Locks onto the sequence, then flags wraps, flips and errors.
module count_stream_checker
  import count_stream_checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_VAL  = DEF_MAX_VAL,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             wrap_pulse,
  output logic             flip_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_LEN + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_LEN);
  localparam logic [MW-1:0] ONE = MW'(1);
  localparam logic [MW-1:0] TWO = MW'(2);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [MW-1:0]    mcnt, mcnt_n;
  logic             dir_n;
  logic [WIDTH-1:0] exp_n;
  logic             wrap_n, flip_n, err_n;
  logic [ERR_W-1:0] ecnt_n;

  logic [WIDTH-1:0] p_up, p_dn, i_up, i_dn;
  logic             p_up_w, p_dn_w, i_up_w, i_dn_w;

  logic             oor;
  logic             st_unl, st_acq, st_lck;
  logic             hit, nd;
  logic [MW-1:0]    inc;
  logic [ERR_W-1:0] ecnt_sat;

  count_step #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_p_up (
    .x(prev), .up(1'b1), .y(p_up), .wrap(p_up_w)
  );
  count_step #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_p_dn (
    .x(prev), .up(1'b0), .y(p_dn), .wrap(p_dn_w)
  );
  count_step #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_i_up (
    .x(count_in), .up(1'b1), .y(i_up), .wrap(i_up_w)
  );
  count_step #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_i_dn (
    .x(count_in), .up(1'b0), .y(i_dn), .wrap(i_dn_w)
  );

  assign oor    = (count_in > WIDTH'(MAX_VAL));
  assign st_unl = !oor && (state == ST_UNLOCKED);
  assign st_acq = !oor && (state == ST_ACQUIRE);
  assign st_lck = !oor && (state == ST_LOCKED);
  assign locked = (state == ST_LOCKED);
  assign ecnt_sat = (&err_count) ? err_count : err_count + ERR_W'(1);

  // Next-state decode for one valid sample
  always_comb begin
    state_n = state;
    prev_n  = prev;
    mcnt_n  = mcnt;
    dir_n   = dir;
    exp_n   = expected;
    wrap_n  = 1'b0;
    flip_n  = 1'b0;
    err_n   = 1'b0;
    ecnt_n  = err_count;
    hit     = 1'b0;
    nd      = dir;
    inc     = mcnt + ONE;
    if (valid) begin
      unique case (1'b1)
        oor: begin
          err_n   = 1'b1;
          ecnt_n  = ecnt_sat;
          state_n = ST_UNLOCKED;
          mcnt_n  = '0;
        end
        st_unl: begin
          prev_n  = count_in;
          mcnt_n  = ONE;
          state_n = ST_ACQUIRE;
        end
        st_acq: begin
          prev_n = count_in;
          if (mcnt < TWO) begin
            if (count_in == p_up) begin
              hit = 1'b1;
              nd  = 1'b1;
            end else if (count_in == p_dn) begin
              hit = 1'b1;
              nd  = 1'b0;
            end
          end else if (count_in == (dir ? p_up : p_dn)) begin
            hit = 1'b1;
          end
          if (hit) begin
            dir_n  = nd;
            mcnt_n = inc;
            if (inc == LOCK_N) begin
              state_n = ST_LOCKED;
              exp_n   = nd ? i_up : i_dn;
            end
          end else begin
            mcnt_n = ONE;
          end
        end
        st_lck: begin
          if (count_in == expected) begin
            prev_n = count_in;
            exp_n  = dir ? i_up : i_dn;
            wrap_n = dir ? p_up_w : p_dn_w;
          end else if (count_in == (dir ? p_dn : p_up)) begin
            prev_n = count_in;
            dir_n  = !dir;
            flip_n = 1'b1;
            wrap_n = dir ? p_dn_w : p_up_w;
            exp_n  = dir ? i_dn : i_up;
          end else begin
            err_n   = 1'b1;
            ecnt_n  = ecnt_sat;
            state_n = ST_ACQUIRE;
            prev_n  = count_in;
            mcnt_n  = ONE;
          end
        end
        default: state_n = ST_UNLOCKED;
      endcase
    end
  end

  // Register all state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_UNLOCKED;
      prev       <= '0;
      mcnt       <= '0;
      dir        <= 1'b0;
      expected   <= '0;
      wrap_pulse <= 1'b0;
      flip_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      mcnt       <= mcnt_n;
      dir        <= dir_n;
      expected   <= exp_n;
      wrap_pulse <= wrap_n;
      flip_pulse <= flip_n;
      err_pulse  <= err_n;
      err_count  <= ecnt_n;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{i_up_w, i_dn_w};

endmodule

// File: tb/tb_count_stream_checker.sv
// Bench for count_stream_checker: scripted samples with queued
// expected responses; a 2-bit error-counter copy shares the inputs.
module tb_count_stream_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [4:0] count_in = '0;

  logic       locked, dir, wrap_pulse, flip_pulse, err_pulse;
  logic [4:0] expected;
  logic [7:0] err_count;

  logic       locked2, dir2, wrap2, flip2, err2;
  logic [4:0] expected2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int in;
    int l;
    int d;
    int x;
    int w;
    int f;
    int e;
    int c;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  count_stream_checker dut (
    .clk(clk), .rst(rst), .valid(valid), .count_in(count_in),
    .locked(locked), .dir(dir), .expected(expected),
    .wrap_pulse(wrap_pulse), .flip_pulse(flip_pulse),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  count_stream_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid(valid), .count_in(count_in),
    .locked(locked2), .dir(dir2), .expected(expected2),
    .wrap_pulse(wrap2), .flip_pulse(flip2),
    .err_pulse(err2), .err_count(err_count2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] want
  );
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic cmp(input exp_t t);
    string s;
    int c2;
    s  = $sformatf("in%0d", t.in);
    c2 = (t.c > 3) ? 3 : t.c;
    chk({s, " locked"}, 32'(locked), t.l);
    chk({s, " wrap"}, 32'(wrap_pulse), t.w);
    chk({s, " flip"}, 32'(flip_pulse), t.f);
    chk({s, " err"}, 32'(err_pulse), t.e);
    chk({s, " errcnt"}, 32'(err_count), t.c);
    chk({s, " locked2"}, 32'(locked2), t.l);
    chk({s, " wrap2"}, 32'(wrap2), t.w);
    chk({s, " flip2"}, 32'(flip2), t.f);
    chk({s, " err2"}, 32'(err2), t.e);
    chk({s, " errcnt2"}, 32'(err_count2), c2);
    if (t.l != 0) begin
      chk({s, " dir"}, 32'(dir), t.d);
      chk({s, " expected"}, 32'(expected), t.x);
      chk({s, " dir2"}, 32'(dir2), t.d);
      chk({s, " expected2"}, 32'(expected2), t.x);
    end
  endtask

  // v=0 drives a gap cycle with a garbage count on the bus
  task automatic send(
    input int v, input int in,
    input int l, input int d, input int x,
    input int w, input int f, input int e, input int c
  );
    exp_t t;
    t.in = v ? in : -1;
    t.l = l; t.d = d; t.x = x;
    t.w = w; t.f = f; t.e = e; t.c = c;
    sb.push_back(t);
    valid    = (v != 0);
    count_in = 5'(in);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty");
    end else begin
      cmp(sb.pop_front());
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " locked"}, 32'(locked), 0);
    chk({tag, " wrap"}, 32'(wrap_pulse), 0);
    chk({tag, " flip"}, 32'(flip_pulse), 0);
    chk({tag, " err"}, 32'(err_pulse), 0);
    chk({tag, " errcnt"}, 32'(err_count), 0);
    chk({tag, " dir"}, 32'(dir), 0);
    chk({tag, " expected"}, 32'(expected), 0);
    chk({tag, " errcnt2"}, 32'(err_count2), 0);
    chk({tag, " locked2"}, 32'(locked2), 0);
  endtask

  initial begin
    #3;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // up lock then wrap 30->0
    send(1, 27, 0, 0, 0, 0, 0, 0, 0);
    send(1, 28, 0, 0, 0, 0, 0, 0, 0);
    send(1, 29, 1, 1, 30, 0, 0, 0, 0);
    send(1, 30, 1, 1, 0, 0, 0, 0, 0);
    send(1, 0, 1, 1, 1, 1, 0, 0, 0);
    // gaps leave lock and prediction alone
    send(0, 31, 1, 1, 1, 0, 0, 0, 0);
    send(0, 17, 1, 1, 1, 0, 0, 0, 0);
    send(1, 1, 1, 1, 2, 0, 0, 0, 0);
    for (int i = 2; i <= 10; i++)
      send(1, i, 1, 1, i + 1, 0, 0, 0, 0);
    // flip down, then back up
    send(1, 9, 1, 0, 8, 0, 1, 0, 0);
    send(1, 8, 1, 0, 7, 0, 0, 0, 0);
    send(1, 9, 1, 1, 10, 0, 1, 0, 0);
    send(1, 10, 1, 1, 11, 0, 0, 0, 0);
    // sequence error and relock
    send(1, 20, 0, 0, 0, 0, 0, 1, 1);
    send(1, 21, 0, 0, 0, 0, 0, 0, 1);
    send(1, 22, 1, 1, 23, 0, 0, 0, 1);
    // down lock, wrap 0->30, then flip+wrap 30->0
    send(1, 2, 0, 0, 0, 0, 0, 1, 2);
    send(1, 1, 0, 0, 0, 0, 0, 0, 2);
    send(1, 0, 1, 0, 30, 0, 0, 0, 2);
    send(1, 30, 1, 0, 29, 1, 0, 0, 2);
    send(1, 0, 1, 1, 1, 1, 1, 0, 2);
    // out of range drops to unlocked
    send(1, 31, 0, 0, 0, 0, 0, 1, 3);
    send(1, 5, 0, 0, 0, 0, 0, 0, 3);
    send(1, 6, 0, 0, 0, 0, 0, 0, 3);
    send(1, 7, 1, 1, 8, 0, 0, 0, 3);
    // acquire restart without error, 2-bit counter saturates
    send(1, 31, 0, 0, 0, 0, 0, 1, 4);
    send(1, 5, 0, 0, 0, 0, 0, 0, 4);
    send(1, 9, 0, 0, 0, 0, 0, 0, 4);
    send(1, 10, 0, 0, 0, 0, 0, 0, 4);
    send(1, 11, 1, 1, 12, 0, 0, 0, 4);
    send(1, 31, 0, 0, 0, 0, 0, 1, 5);
    send(1, 12, 0, 0, 0, 0, 0, 0, 5);
    send(1, 13, 0, 0, 0, 0, 0, 0, 5);
    send(1, 14, 1, 1, 15, 0, 0, 0, 5);
    send(1, 20, 0, 0, 0, 0, 0, 1, 6);

    // async reset while err_pulse is high
    valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    send(1, 3, 0, 0, 0, 0, 0, 0, 0);
    send(1, 4, 0, 0, 0, 0, 0, 0, 0);
    send(1, 5, 1, 1, 6, 0, 0, 0, 0);
    valid = 1'b0;

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover %0d", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
